mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core.
//  Sits beside the EX-stage ALU; the hazard unit stalls on busy for mult/div/mfhi/mflo/mthi/mtlo.
//  Adds over the single-cycle datapath: multi-cycle latency, busy/done handshake, flush-cancel.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1      single clock, rising edge
//  reset   in   1      asynchronous, active-low (0 = reset)
//  start   in   1      request; op/rs_val/rt_val sampled on the same edge
//  op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//  rs_val  in   WIDTH  operand A / dividend / MTHI-MTLO source
//  rt_val  in   WIDTH  operand B / divisor
//  cancel  in   1      exception flush: abandon in-flight op
//  busy    out  1      operation in flight
//  done    out  1      one-cycle pulse on the edge HI/LO commit
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-op): hi=0, lo=0, busy=0, done=0, state IDLE, pending discarded.
//  - FSM states: IDLE, MUL_BUSY, DIV_BUSY; counter cnt, width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  - IDLE & start & op MULT/MULTU: latch full 2*WIDTH product into pending; cnt=MULT_CYCLES; -> MUL_BUSY.
//  - IDLE & start & op DIV/DIVU: latch {rem,quot} into pending; cnt=DIV_CYCLES; -> DIV_BUSY.
//  - IDLE & start & MTHI/MTLO: hi/lo <= rs_val on that edge; busy stays 0; done not pulsed.
//  - IDLE & start & op 6-7: no effect.
//  - busy = (state != IDLE), registered. Start edge t -> busy high for exactly N cycles after t.
//  - In BUSY: cnt decrements each edge; on the edge where cnt==1: hi/lo <= pending, done=1
//    for the following cycle, -> IDLE. A start on the cycle after that commit is accepted.
//  - hi/lo hold their old values throughout busy; no partial results are ever visible.
//  - start while busy: ignored, including MTHI/MTLO (the pipeline must stall; no queueing).
//  - cancel: when busy -> IDLE next edge, pending discarded, hi/lo unchanged, done=0.
//    cancel in IDLE: no effect. cancel & start on the same edge: cancel wins, start dropped.
//    cancel on the commit edge (cnt==1): cancel wins, no commit.
//  - Arithmetic rules:
//    MULT: signed WIDTH x WIDTH -> 2*WIDTH; hi = upper WIDTH bits, lo = lower WIDTH bits.
//    MULTU: same, unsigned operands.
//    DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//    DIVU: unsigned quotient/remainder.
//    Divisor 0 (DIV or DIVU): op still runs DIV_CYCLES; hi/lo retain prior values; done still pulses.
//    DIV of INT_MIN by -1: lo = INT_MIN, hi = 0; no trap.
// STRUCTURE
//  - mdu_pkg: op encodings (MDU_MULT..MDU_MTLO), state enum (S_IDLE, S_MUL, S_DIV).
//  - Sub-module mdu_arith: combinational; computes {hi_n, lo_n} and a div-by-zero flag from op/rs/rt.
//  - mdu_unit holds the FSM, counter, pending regs, and HI/LO registers.
// TESTING
//  1 MULT rs=FFFFFFFD (-3), rt=5 -> busy 5 cycles; then hi=FFFFFFFF, lo=FFFFFFF1, one done pulse.
//  2 DIVU 7/2 -> busy 10 cycles; hi=1, lo=3. DIV FFFFFFF9/2 -> hi=FFFFFFFF, lo=FFFFFFFD.
//  3 MTHI 12345678 in IDLE -> hi=12345678 next edge, busy=0.
//    MULT in flight then MTLO and a 2nd MULT -> both ignored; only the 1st result lands.
//  4 DIV 9/3 with cancel at busy cycle 4 -> busy=0 next edge, hi/lo unchanged, no done.
//    cancel+start same edge -> nothing starts.
//  5 DIV 5/0 with hi=AA, lo=BB -> busy 10, done pulses, hi=AA, lo=BB.
//    DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  6 reset=0 at MULT busy cycle 2 -> hi=lo=0, busy=0 immediately.
//    After reset release, MULTU FFFFFFFF*2 -> hi=1, lo=FFFFFFFE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU arithmetic: full-width products and truncating quotient/remainder.
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rt,
   output logic [WIDTH-1:0] o_hi_n,
   output logic [WIDTH-1:0] o_lo_n,
   output logic             o_div_zero
);

   logic [2*WIDTH-1:0] w_prod_s;
   logic [2*WIDTH-1:0] w_prod_u;
   logic               w_sgn;
   logic               w_neg_a;
   logic               w_neg_b;
   logic               w_rt_zero;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH-1:0]   w_den;
   logic [WIDTH-1:0]   w_uq;
   logic [WIDTH-1:0]   w_ur;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;

   // Sign-extending to 2*WIDTH makes the modular product equal the signed product.
   assign w_prod_s = {{WIDTH{i_rs[WIDTH-1]}}, i_rs} * {{WIDTH{i_rt[WIDTH-1]}}, i_rt};
   assign w_prod_u = {{WIDTH{1'b0}}, i_rs} * {{WIDTH{1'b0}}, i_rt};

   // Signed divide works on magnitudes; INT_MIN's magnitude fits as unsigned, so INT_MIN/-1 wraps to INT_MIN.
   assign w_sgn     = (i_op == MDU_DIV);
   assign w_neg_a   = w_sgn & i_rs[WIDTH-1];
   assign w_neg_b   = w_sgn & i_rt[WIDTH-1];
   assign w_mag_a   = w_neg_a ? (~i_rs + WIDTH'(1)) : i_rs;
   assign w_mag_b   = w_neg_b ? (~i_rt + WIDTH'(1)) : i_rt;
   assign w_rt_zero = (i_rt == '0);
   assign w_den     = w_rt_zero ? WIDTH'(1) : w_mag_b;
   assign w_uq      = w_mag_a / w_den;
   assign w_ur      = w_mag_a % w_den;
   assign w_quot    = (w_neg_a ^ w_neg_b) ? (~w_uq + WIDTH'(1)) : w_uq;
   assign w_rem     = w_neg_a ? (~w_ur + WIDTH'(1)) : w_ur;

   always_comb begin
      o_hi_n     = '0;
      o_lo_n     = '0;
      o_div_zero = 1'b0;
      case (i_op)
         MDU_MULT:  {o_hi_n, o_lo_n} = w_prod_s;
         MDU_MULTU: {o_hi_n, o_lo_n} = w_prod_u;
         MDU_DIV, MDU_DIVU: begin
            o_hi_n     = w_rem;
            o_lo_n     = w_quot;
            o_div_zero = w_rt_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy/done handshake and flush-cancel.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   mdu_state_e         r_state;
   mdu_state_e         w_state_n;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_n;
   logic [2*WIDTH-1:0] r_pend;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               w_load;
   logic               w_commit;
   logic               w_mthi;
   logic               w_mtlo;
   logic [WIDTH-1:0]   w_hi_n;
   logic [WIDTH-1:0]   w_lo_n;
   logic               w_div_zero;

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .i_op       (op),
      .i_rs       (rs_val),
      .i_rt       (rt_val),
      .o_hi_n     (w_hi_n),
      .o_lo_n     (w_lo_n),
      .o_div_zero (w_div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
      end
   end

   // Cancel has priority over both a new start and the commit edge.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_load    = 1'b0;
      w_commit  = 1'b0;
      w_mthi    = 1'b0;
      w_mtlo    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !cancel) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     w_state_n = S_MUL;
                     w_cnt_n   = CW'(MULT_CYCLES);
                     w_load    = 1'b1;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     w_state_n = S_DIV;
                     w_cnt_n   = CW'(DIV_CYCLES);
                     w_load    = 1'b1;
                  end
                  MDU_MTHI: w_mthi = 1'b1;
                  MDU_MTLO: w_mtlo = 1'b1;
                  default: ;
               endcase
            end
         end
         default: begin
            if (cancel) begin
               w_state_n = S_IDLE;
            end else if (r_cnt == CW'(1)) begin
               w_state_n = S_IDLE;
               w_commit  = 1'b1;
            end else begin
               w_cnt_n = r_cnt - CW'(1);
            end
         end
      endcase
   end

   // A zero divisor captures the current HI/LO so the commit rewrites them unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_load) r_pend <= w_div_zero ? {r_hi, r_lo} : {w_hi_n, w_lo_n};
         if (w_commit) {r_hi, r_lo} <= r_pend;
         if (w_mthi) r_hi <= rs_val;
         if (w_mtlo) r_lo <= rs_val;
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed scoreboard bench for mdu_unit: expected HI/LO queued at issue, checked on each done pulse.
module tb_mdu_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  dbg_state;

   int          total;
   int          bad;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .cancel    (cancel),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued result.
   always @(negedge clk) begin
      if (reset && done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h expected no pulse", hi, lo);
         end else begin
            mon_e = exp_q.pop_front();
            chk("commit_hilo", {hi, lo}, mon_e);
         end
      end
   end

   // mode 1 drives an MTLO then a MULT while busy; both must be ignored.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [63:0] exp, input int mode);
      int cnt;
      cnt = 0;
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, "_busy_start"}, {63'd0, busy}, 64'd1);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
         chk({name, "_hold"}, {hi, lo}, {m_hi, m_lo});
         if (mode == 1 && cnt == 1) begin
            start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF;
         end else if (mode == 1 && cnt == 2) begin
            op = 3'd0; rs_val = 32'd7; rt_val = 32'd7;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({name, "_busy_cycles"}, 64'(cnt), 64'(n));
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, {63'd0, done}, 64'd0);
      chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      chk({name, "_final"}, {hi, lo}, exp);
   endtask

   task automatic move_to(input string name, input logic [2:0] o, input logic [31:0] a);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      if (o == 3'd4) m_hi = a;
      else m_lo = a;
      chk({name, "_hilo"}, {hi, lo}, {m_hi, m_lo});
      chk({name, "_busy"}, {63'd0, busy}, 64'd0);
      chk({name, "_done"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0; cancel = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
      chk("reset_state", {62'd0, dbg_state}, 64'd0);

      run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 5, 64'hFFFFFFFF_FFFFFFF1, 0);
      run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 10, 64'h00000001_00000003, 0);
      run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD, 0);
      move_to("mthi", 3'd4, 32'h12345678);
      run_op("mult_ignore", 3'd0, 32'd3, 32'd4, 5, 64'h00000000_0000000C, 1);

      // Cancel a divide at busy cycle 4.
      @(negedge clk);
      start = 1'b1; op = 3'd2; rs_val = 32'd9; rt_val = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      chk("cancel_busy_start", {63'd0, busy}, 64'd1);
      repeat (4) @(negedge clk);
      cancel = 1'b1;
      @(posedge clk); #1;
      chk("cancel_busy", {63'd0, busy}, 64'd0);
      chk("cancel_hilo", {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
      cancel = 1'b0;
      repeat (12) @(negedge clk);
      chk("cancel_late_hilo", {hi, lo}, {m_hi, m_lo});

      // Cancel together with start: nothing begins.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = 3'd2; rs_val = 32'd9; rt_val = 32'd3;
      @(posedge clk); #1;
      chk("cancel_start_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      repeat (3) @(negedge clk);
      chk("cancel_start_hilo", {hi, lo}, {m_hi, m_lo});

      move_to("mthi_aa", 3'd4, 32'h000000AA);
      move_to("mtlo_bb", 3'd5, 32'h000000BB);
      run_op("div_by_0", 3'd2, 32'd5, 32'd0, 10, 64'h000000AA_000000BB, 0);
      run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 64'h00000000_80000000, 0);

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midreset_hilo", {hi, lo}, 64'd0);
      chk("midreset_busy_done", {62'd0, busy, done}, 64'd0);
      chk("midreset_state", {62'd0, dbg_state}, 64'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("postreset_hilo", {hi, lo}, 64'd0);

      run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 64'h00000001_FFFFFFFE, 0);

      repeat (3) @(negedge clk);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
